// File: rtl/speed_tick_gen_pkg.sv
// Shared defaults and command encoding for the programmable sample-rate tick generator.
package speed_tick_gen_pkg;

  localparam int DEF_CLK_HZ   = 50_000_000;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_BASE_DIV = 2272;
  localparam int DEF_STEP     = 64;
  localparam int DEF_MIN_DIV  = 256;
  localparam int DEF_MAX_DIV  = 65535;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DN,
    CMD_RST
  } speed_cmd_t;

  // Reset wins; simultaneous up and down cancel out.
  function automatic speed_cmd_t decode_cmd(input logic up, input logic dn, input logic rst);
    speed_cmd_t cmd;
    cmd = CMD_NONE;
    if (rst)            cmd = CMD_RST;
    else if (up && !dn) cmd = CMD_UP;
    else if (dn && !up) cmd = CMD_DN;
    return cmd;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous board level, followed by a registered
// rising-edge pulse that appears on the third clock edge after the input rises.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/speed_tick_gen.sv
// Programmable tick generator: 1-cycle strobe every div_value cycles plus a square wave
// toggling on each strobe. Divisor steps are staged and only applied at a period boundary.
module speed_tick_gen
  import speed_tick_gen_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int BASE_DIV = DEF_BASE_DIV,
  parameter int STEP     = DEF_STEP,
  parameter int MIN_DIV  = DEF_MIN_DIV,
  parameter int MAX_DIV  = DEF_MAX_DIV
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             speed_up,
  input  logic             speed_dn,
  input  logic             speed_rst,
  input  logic             enable,
  output logic             tick_out,
  output logic             sq_out,
  output logic [WIDTH-1:0] div_value
);

  localparam logic [WIDTH-1:0] BASE_W    = WIDTH'(BASE_DIV);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_DIV);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MIN_X     = (WIDTH+1)'(MIN_DIV);
  localparam logic [WIDTH:0]   MAX_X     = (WIDTH+1)'(MAX_DIV);

  logic up_pulse, dn_pulse, rst_pulse;
  speed_cmd_t cmd;

  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [WIDTH-1:0] act_div_q,  act_div_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic             tick_q,     tick_d;
  logic             sq_q,       sq_d;

  logic [WIDTH:0]   pend_x;
  logic [WIDTH:0]   dec_x;
  logic [WIDTH:0]   inc_x;
  logic             wrap;

  sync_edge_det u_sync_up (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .async_in  (speed_up),
    .pulse_out (up_pulse)
  );

  sync_edge_det u_sync_dn (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .async_in  (speed_dn),
    .pulse_out (dn_pulse)
  );

  sync_edge_det u_sync_rst (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .async_in  (speed_rst),
    .pulse_out (rst_pulse)
  );

  // One extra bit of headroom keeps the step arithmetic from wrapping before saturation.
  always_comb begin
    cmd        = decode_cmd(up_pulse, dn_pulse, rst_pulse);
    pend_x     = {1'b0, pend_div_q};
    dec_x      = pend_x - STEP_X;
    inc_x      = pend_x + STEP_X;
    pend_div_d = pend_div_q;
    case (cmd)
      CMD_RST: pend_div_d = BASE_W;
      CMD_UP:  pend_div_d = (pend_x < MIN_X + STEP_X) ? MIN_W : dec_x[WIDTH-1:0];
      CMD_DN:  pend_div_d = (inc_x > MAX_X) ? MAX_W : inc_x[WIDTH-1:0];
      default: pend_div_d = pend_div_q;
    endcase
  end

  // The active divisor is reloaded only at the wrap, so a period is never cut short.
  always_comb begin
    wrap      = (cnt_q == act_div_q - WIDTH'(1));
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    sq_d      = sq_q;
    tick_d    = 1'b0;
    if (enable) begin
      if (wrap) begin
        cnt_d     = '0;
        act_div_d = pend_div_q;
        sq_d      = ~sq_q;
        tick_d    = 1'b1;
      end else begin
        cnt_d     = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pend_div_q <= BASE_W;
      act_div_q  <= BASE_W;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      sq_q       <= 1'b0;
    end else begin
      pend_div_q <= pend_div_d;
      act_div_q  <= act_div_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick_out  = tick_q;
  assign sq_out    = sq_q;
  assign div_value = act_div_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Randomised and directed bench for speed_tick_gen with a cycle-level reference model.
module tb_speed_tick_gen;

  localparam int WIDTH    = 16;
  localparam int BASE_DIV = 8;
  localparam int STEP     = 2;
  localparam int MIN_DIV  = 4;
  localparam int MAX_DIV  = 12;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             speed_up = 1'b0;
  logic             speed_dn = 1'b0;
  logic             speed_rst = 1'b0;
  logic             enable = 1'b1;
  logic             tick_out;
  logic             sq_out;
  logic [WIDTH-1:0] div_value;

  int vectors = 0;
  int errors  = 0;

  speed_tick_gen #(
    .CLK_HZ   (50_000_000),
    .WIDTH    (WIDTH),
    .BASE_DIV (BASE_DIV),
    .STEP     (STEP),
    .MIN_DIV  (MIN_DIV),
    .MAX_DIV  (MAX_DIV)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .speed_up  (speed_up),
    .speed_dn  (speed_dn),
    .speed_rst (speed_rst),
    .enable    (enable),
    .tick_out  (tick_out),
    .sq_out    (sq_out),
    .div_value (div_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: elapsed cycles in the current period, staged and active divisors,
  // and the raw input level seen at each of the last three edges.
  int   m_elapsed, m_act, m_pend, m_old_pend;
  bit   m_tick, m_sq, m_valid;
  bit   p_up, p_dn, p_rst;
  bit [2:0] h_up, h_dn, h_rst;

  always @(posedge clk_in) begin
    if (!rst_n) begin
      m_elapsed = 0; m_act = BASE_DIV; m_pend = BASE_DIV;
      m_tick = 0; m_sq = 0; m_valid = 1;
      p_up = 0; p_dn = 0; p_rst = 0;
      h_up = '0; h_dn = '0; h_rst = '0;
    end else begin
      m_old_pend = m_pend;
      if (p_rst)              m_pend = BASE_DIV;
      else if (p_up && !p_dn) m_pend = (m_pend - STEP < MIN_DIV) ? MIN_DIV : m_pend - STEP;
      else if (p_dn && !p_up) m_pend = (m_pend + STEP > MAX_DIV) ? MAX_DIV : m_pend + STEP;
      m_tick = 0;
      if (enable) begin
        m_elapsed++;
        if (m_elapsed == m_act) begin
          m_elapsed = 0;
          m_tick = 1;
          m_sq = !m_sq;
          m_act = m_old_pend;
        end
      end
      // An event fires when the level was high two edges ago but low three edges ago.
      p_up  = h_up[1]  & ~h_up[2];
      p_dn  = h_dn[1]  & ~h_dn[2];
      p_rst = h_rst[1] & ~h_rst[2];
      h_up  = {h_up[1:0],  speed_up};
      h_dn  = {h_dn[1:0],  speed_dn};
      h_rst = {h_rst[1:0], speed_rst};
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("tick_out",  int'(tick_out),  int'(m_tick));
      check("sq_out",    int'(sq_out),    int'(m_sq));
      check("div_value", int'(div_value), m_act);
    end
  end

  // Returns the number of falling edges until tick_out is seen high, or -1 on timeout.
  task automatic wait_tick(output int k);
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_in);
      if (tick_out) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (40) @(negedge clk_in);
  endtask

  task automatic pulse_up();
    speed_up = 1'b1; repeat (4) @(negedge clk_in);
    speed_up = 1'b0; repeat (4) @(negedge clk_in);
  endtask

  task automatic pulse_dn();
    speed_dn = 1'b1; repeat (4) @(negedge clk_in);
    speed_dn = 1'b0; repeat (4) @(negedge clk_in);
  endtask

  task automatic pulse_rst();
    speed_rst = 1'b1; repeat (4) @(negedge clk_in);
    speed_rst = 1'b0; repeat (4) @(negedge clk_in);
  endtask

  initial begin
    int k, nticks, sq_hold, found;

    repeat (3) @(negedge clk_in);
    check("reset_div", int'(div_value), 8);
    check("reset_sq", int'(sq_out), 0);
    check("reset_tick", int'(tick_out), 0);
    rst_n = 1'b1;

    wait_tick(k);
    check("first_tick_delay", k, 8);
    check("sq_after_first_tick", int'(sq_out), 1);
    wait_tick(k);
    check("second_period", k, 8);
    check("sq_after_second_tick", int'(sq_out), 0);

    // One step faster, requested at the start of a period.
    speed_up = 1'b1;
    wait_tick(k);
    speed_up = 1'b0;
    check("period_before_load", k, 8);
    check("div_after_up", int'(div_value), 6);
    wait_tick(k);
    check("period_after_up", k, 6);

    pulse_up(); settle();
    check("div_up2", int'(div_value), 4);
    pulse_up(); settle();
    check("div_up3_saturated", int'(div_value), 4);
    wait_tick(k); wait_tick(k);
    check("period_at_min", k, 4);

    pulse_rst(); settle();
    check("div_after_rst", int'(div_value), 8);

    speed_dn = 1'b1; repeat (100) @(negedge clk_in);
    speed_dn = 1'b0; settle();
    check("div_dn_held", int'(div_value), 10);
    pulse_dn(); settle();
    check("div_dn2", int'(div_value), 12);
    pulse_dn(); settle();
    check("div_dn3_saturated", int'(div_value), 12);
    pulse_rst(); settle();
    check("div_rst_from_max", int'(div_value), 8);

    speed_up = 1'b1; speed_dn = 1'b1; repeat (4) @(negedge clk_in);
    speed_up = 1'b0; speed_dn = 1'b0; settle();
    check("div_up_dn_cancel", int'(div_value), 8);

    // Pause with three cycles of the period already elapsed.
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_elapsed == 3) begin found = 1; break; end
      @(negedge clk_in);
    end
    check("found_count3", found, 1);
    enable = 1'b0;
    sq_hold = int'(sq_out);
    nticks = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (tick_out) nticks++;
    end
    check("ticks_while_paused", nticks, 0);
    check("sq_frozen", int'(sq_out), sq_hold);
    enable = 1'b1;
    wait_tick(k);
    check("resume_delay", k, 5);

    // Reset while a faster divisor is staged: it must be discarded.
    speed_up = 1'b1;
    repeat (5) @(negedge clk_in);
    rst_n = 1'b0; speed_up = 1'b0;
    @(negedge clk_in);
    check("midreset_div", int'(div_value), 8);
    check("midreset_sq", int'(sq_out), 0);
    rst_n = 1'b1;
    wait_tick(k);
    check("midreset_first_tick", k, 8);
    wait_tick(k);
    check("midreset_pending_lost", k, 8);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 11) == 0) speed_up  = ~speed_up;
      if ($urandom_range(0, 11) == 0) speed_dn  = ~speed_dn;
      if ($urandom_range(0, 40) == 0) speed_rst = ~speed_rst;
      if ($urandom_range(0, 9) == 0)  enable    = ~enable;
      rst_n = ($urandom_range(0, 400) != 0);
    end
    rst_n = 1'b1; enable = 1'b1;
    repeat (20) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
